console_uart_tx: RTL and testbench
==================================

Name: console_uart_tx

Overview:
- Consumer end of the core's console write port (console_we / console_wdata).
- Buffers each byte the core writes and serialises it as 8N1 UART on a board TX pin.
- Sits in the FPGA top level beside seven_seg and is driven directly by bbq's console outputs.
- Never stalls the core: a write to a full buffer is dropped and flagged.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 16, byte entries; must be a power of two, >= 2.
- Derived localparam CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD. Elaboration fails if this is < 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  console write strobe from core; one byte per high cycle.
- wdata  input  XLEN  console write data; only [7:0] used, upper bits ignored.
- tx  output  1  UART serial line; idles high.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; set when a write is dropped.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset (reset low, async): tx=1, full=0, overflow=0, busy=0, FIFO emptied, state=IDLE, bit/baud counters=0. Takes effect immediately, including mid-frame; the line returns to idle-high with no partial stop bit.
- Write acceptance:
  - On a clk edge with we=1 and full=0 (value before this edge), wdata[7:0] is pushed.
  - we=1 with full=1 drops the byte and sets overflow, even if a pop occurs on the same edge.
  - Push and pop on the same edge with 0 < count < FIFO_DEPTH leaves count unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- full = (count == FIFO_DEPTH).
- State machine (baud counter counts 0..CLKS_PER_BIT-1; "bit end" = counter at CLKS_PER_BIT-1):
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, tx<=0, counter<=0, go to START.
  - START: hold tx=0. At bit end: tx<=shift[0], bit index<=0, go to DATA.
  - DATA: at bit end, shift right and increment index. After index 7 completes: tx<=1, go to STOP.
  - STOP: hold tx=1. At bit end: if FIFO non-empty, pop, tx<=0, go to START (no idle gap); else go to IDLE.
- Latency: a byte written into an empty FIFO while IDLE is captured at edge E0; tx falls at edge E0+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10*CLKS_PER_BIT cycles. LSB first.
- busy = (state != IDLE) || (count != 0). It deasserts on the same edge the last stop bit ends with the FIFO empty.
- overflow clears only on reset.
- tx is driven from a register; no combinational path from we to tx.

Decomposition:
- State encodings (IDLE/START/DATA/STOP, 2 bits) go in fpga_constants.vh.
- XLEN comes from constants.vh.
- One sub-module: byte_fifo (synchronous, single clock, async active-low reset). Parameters DEPTH and WIDTH=8. Ports push, pop, din, dout (registered head), count, full, empty.
- console_uart_tx holds the baud counter, bit index, shift register, state machine and overflow flag.
- Top-level integration: connect bbq console_we/console_wdata to we/wdata and route tx to the board UART pin.

Test Plan (CLK_HZ=16, BAUD=1, so CLKS_PER_BIT=16; FIFO_DEPTH=4):
- Single byte: write 0x55 once -> tx low 1 cycle after the write edge for 16 cycles. Then data 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16. busy low exactly 160 cycles after tx fell.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles -> two frames with no idle gap; second start bit begins the cycle after the first stop bit ends. Decoded bytes are 0xA5, 0x3C.
- Full and overflow: 6 consecutive writes 0x01..0x06 while idle -> first byte popped immediately. 0x02..0x05 fill the FIFO (full=1); 0x06 dropped, overflow=1. Line carries 0x01..0x05 only; overflow stays 1 afterwards.
- Upper bits ignored: wdata=0xDEADBE7F -> transmitted byte 0x7F.
- Reset mid-frame: assert reset during DATA bit 3 of 0xF0 with 2 bytes queued -> tx=1 asynchronously, busy=0, full=0, overflow=0. After release, no further frames without new writes.
- Push/pop same edge: FIFO at count 2, write during the STOP-end pop edge -> count stays 2 and no byte is lost or duplicated.

Source files
------------

// File: rtl/console_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// console_uart_tx_pkg
// Shared constants and helpers for the console UART transmitter slice.
//   XLEN               : width of the core's console write data bus
//   ST_IDLE..ST_STOP   : 2-bit transmitter state encodings
//   uart_byte_t        : one serialised character
//   calc_clks_per_bit  : rounded clock-to-baud divider
// ---------------------------------------------------------------------------
package console_uart_tx_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef logic [7:0] uart_byte_t;

    // Round to the nearest whole number of clocks per bit so the baud error
    // stays within half a clock.
    function automatic int calc_clks_per_bit(input int clkHz, input int baud);
        return (clkHz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/console_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Single-clock synchronous FIFO buffering console bytes ahead of the UART.
//   clk    : system clock
//   reset  : asynchronous, active-low reset (empties the FIFO)
//   push   : write din this edge (ignored while full)
//   pop    : advance the head this edge (ignored while empty)
//   din    : byte to write
//   dout   : current head entry, read straight from the storage registers
//   count  : number of entries held (0..DEPTH)
//   full   : count == DEPTH
//   empty  : count == 0
// ---------------------------------------------------------------------------
module byte_fifo
    import console_uart_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
        $error("byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             pushOk;
    logic             popOk;

    // Guarding here keeps the pointers consistent whatever the caller does.
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;

    // Pointers carry one extra bit so full and empty are distinguishable;
    // they simply wrap and the difference is always the occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    // Storage is left unreset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rdPtr_q[AW-1:0]];
    assign count = wrPtr_q - rdPtr_q;
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/console_uart_tx.sv
// ---------------------------------------------------------------------------
// console_uart_tx
// Receives bytes from the core's console write port, buffers them and sends
// each one as an 8N1 UART frame (LSB first). The core is never stalled: a
// write while the buffer is full is dropped and flagged in a sticky bit.
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   we       : console write strobe, one byte per high cycle
//   wdata    : console write data, only [7:0] is transmitted
//   tx       : UART serial line, idles high, driven from a register
//   full     : buffer holds FIFO_DEPTH bytes
//   overflow : sticky, set when a write is dropped, cleared only by reset
//   busy     : buffer non-empty or a frame is on the line
// ---------------------------------------------------------------------------
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    output logic            tx,
    output logic            full,
    output logic            overflow,
    output logic            busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int CW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : gBadBaud
        $error("console_uart_tx: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
    end

    logic [1:0]      state_q,   state_d;
    logic [CW-1:0]   baudCnt_q, baudCnt_d;
    logic [2:0]      bitIdx_q,  bitIdx_d;
    uart_byte_t      shift_q,   shift_d;
    logic            tx_q,      tx_d;
    logic            overflow_q;

    logic            fifoPop;
    uart_byte_t      fifoDout;
    logic [AW:0]     fifoCount;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            bitEnd;
    logic [XLEN-9:0] unused_wdata_hi;

    assign unused_wdata_hi = wdata[XLEN-1:8];

    // The FIFO itself refuses a push while full, so the strobe goes straight in.
    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (we),
        .pop   (fifoPop),
        .din   (wdata[7:0]),
        .dout  (fifoDout),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign bitEnd = (baudCnt_q == LAST_TICK);

    // Frame sequencer. tx_d always holds the level for the next bit period,
    // so tx changes on exactly the edge a bit boundary is crossed.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifoPop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d      = 1'b1;
                baudCnt_d = '0;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shift_d = fifoDout;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bitEnd) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bitEnd) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bitEnd) begin
                    baudCnt_d = '0;
                    // Chain straight into the next start bit when more is queued.
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        shift_d = fifoDout;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            default: begin
                tx_d      = 1'b1;
                baudCnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // A dropped write is judged on the full flag before this edge, so a pop
    // on the same edge does not rescue it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (we && fifoFull) begin
            overflow_q <= 1'b1;
        end
    end

    assign tx       = tx_q;
    assign full     = fifoFull;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) || (fifoCount != '0);

endmodule

// File: tb/tb_console_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_console_uart_tx
// Bench for console_uart_tx at CLK_HZ=16, BAUD=1 (16 clocks per bit) and a
// 4-entry FIFO.
// ---------------------------------------------------------------------------
module tb_console_uart_tx;
    import console_uart_tx_pkg::*;

    localparam int BIT_CLKS   = 16;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
    localparam int DEPTH      = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic            tx;
    logic            full;
    logic            overflow;
    logic            busy;

    always #5 clk = ~clk;

    console_uart_tx #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wdata    (wdata),
        .tx       (tx),
        .full     (full),
        .overflow (overflow),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a byte queue plus the time window of the frame on
    // the line. A new frame may start on any edge at or after the previous
    // frame's end whenever the queue held something before that edge.
    int         cyc       = 0;
    int         busyUntil = 0;
    int         frameStart = 0;
    logic [7:0] curByte   = 8'h00;
    logic [7:0] mQ[$];
    logic [7:0] sentQ[$];
    logic       mOvf      = 1'b0;

    // Bytes recovered from the line by the behavioural receiver below.
    logic [7:0] rxQ[$];
    int         framingErrors = 0;
    int         resetCount    = 0;

    typedef struct {
        logic [31:0] wdata;
        logic [7:0]  expByte;
        int          expFallDelay;
        int          expBusyLen;
    } vec_t;

    vec_t vecs[4];

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelEdge(input logic w, input logic [31:0] d);
        int preSize;
        preSize = mQ.size();
        cyc++;
        if (preSize > 0 && cyc >= busyUntil) begin
            curByte    = mQ.pop_front();
            frameStart = cyc;
            busyUntil  = cyc + FRAME_CLKS;
            sentQ.push_back(curByte);
        end
        if (w) begin
            if (preSize == DEPTH) mOvf = 1'b1;
            else                  mQ.push_back(d[7:0]);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        busyUntil = 0;
        mOvf      = 1'b0;
    endtask

    // Line level for the current cycle: bit period 0 is the start bit,
    // 1..8 carry the byte LSB first, 9 is the stop bit.
    function automatic logic expTx();
        int k;
        if (cyc < busyUntil) begin
            k = (cyc - frameStart) / BIT_CLKS;
            if (k == 0)      return 1'b0;
            else if (k <= 8) return curByte[k-1];
            else             return 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput();
        logic [3:0] exp;
        exp = {expTx(), (mQ.size() > 0) || (cyc < busyUntil), mQ.size() == DEPTH, mOvf};
        checkValue($sformatf("cycle%0d tx/busy/full/ovf", cyc), {28'd0, tx, busy, full, overflow}, {28'd0, exp});
    endtask

    // Drive one edge's worth of input, advance the model, then compare
    // just after the edge.
    task automatic applyStimulus(input logic w, input logic [31:0] d);
        we    = w;
        wdata = d;
        @(posedge clk);
        modelEdge(w, d);
        #1;
        we = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0);
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n;
        n = 0;
        while ((busy !== 1'b0 || mQ.size() > 0 || cyc < busyUntil) && n < limit) begin
            applyStimulus(1'b0, 32'd0);
            n++;
        end
        checkValue({name, " idle within budget"}, {31'd0, n < limit}, 32'd1);
        idle(4);
    endtask

    task automatic checkRx(input string name, input logic [7:0] exp[$]);
        checkValue({name, " byte count"}, rxQ.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxQ.size(); i++) begin
            checkValue($sformatf("%s byte%0d", name, i), {24'd0, rxQ[i]}, {24'd0, exp[i]});
        end
        rxQ.delete();
    endtask

    always @(negedge reset) resetCount++;

    // Behavioural UART receiver: mid-bit sampling on falling clock edges.
    initial begin : rxMonitor
        logic [7:0] b;
        logic       ok;
        int         rc;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                rc = resetCount;
                ok = 1'b1;
                repeat (BIT_CLKS / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT_CLKS) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (resetCount == rc) begin
                    if (ok) rxQ.push_back(b);
                    else    framingErrors++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] e[$];
        int         n;
        int         wCyc;
        int         fallCyc;

        reset = 1'b0;
        we    = 1'b0;
        wdata = '0;

        vecs[0] = '{32'h0000_0055, 8'h55, 1, FRAME_CLKS};
        vecs[1] = '{32'hDEAD_BE7F, 8'h7F, 1, FRAME_CLKS};
        vecs[2] = '{32'h0000_0000, 8'h00, 1, FRAME_CLKS};
        vecs[3] = '{32'hFFFF_FFFF, 8'hFF, 1, FRAME_CLKS};

        // Reset state
        #12;
        checkValue("reset tx",       {31'd0, tx},       32'd1);
        checkValue("reset busy",     {31'd0, busy},     32'd0);
        checkValue("reset full",     {31'd0, full},     32'd0);
        checkValue("reset overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        idle(5);

        // Single bytes: latency, frame length and content
        for (int v = 0; v < 4; v++) begin
            rxQ.delete();
            applyStimulus(1'b1, vecs[v].wdata);
            wCyc = cyc;
            n = 0;
            while (tx !== 1'b0 && n < 20) begin
                applyStimulus(1'b0, 32'd0);
                n++;
            end
            fallCyc = cyc;
            checkValue($sformatf("vec%0d fall delay", v), fallCyc - wCyc, vecs[v].expFallDelay);
            n = 0;
            while (busy !== 1'b0 && n < 400) begin
                applyStimulus(1'b0, 32'd0);
                n++;
            end
            checkValue($sformatf("vec%0d busy length", v), cyc - fallCyc, vecs[v].expBusyLen);
            idle(4);
            checkValue($sformatf("vec%0d rx count", v), rxQ.size(), 1);
            if (rxQ.size() > 0)
                checkValue($sformatf("vec%0d rx byte", v), {24'd0, rxQ[0]}, {24'd0, vecs[v].expByte});
            rxQ.delete();
        end

        // Back-to-back frames with no idle gap
        applyStimulus(1'b1, 32'hA5);
        applyStimulus(1'b1, 32'h3C);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            applyStimulus(1'b0, 32'd0);
            n++;
        end
        fallCyc = cyc;
        idle(FRAME_CLKS - 1);
        checkValue("b2b last stop cycle", {31'd0, tx}, 32'd1);
        applyStimulus(1'b0, 32'd0);
        checkValue("b2b second start", {31'd0, tx}, 32'd0);
        checkValue("b2b start spacing", cyc - fallCyc, FRAME_CLKS);
        waitIdle("b2b", 1000);
        e = '{8'hA5, 8'h3C};
        checkRx("b2b", e);

        // Fill the FIFO and overflow it
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, i);
            if (i == 5) begin
                checkValue("fill full", {31'd0, full}, 32'd1);
                checkValue("fill no overflow yet", {31'd0, overflow}, 32'd0);
            end
            if (i == 6) begin
                checkValue("drop overflow", {31'd0, overflow}, 32'd1);
                checkValue("drop still full", {31'd0, full}, 32'd1);
            end
        end
        waitIdle("fill", 2000);
        e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        checkRx("fill", e);
        checkValue("overflow sticky", {31'd0, overflow}, 32'd1);

        // Push on the same edge as the stop-end pop, with two bytes queued
        applyStimulus(1'b1, 32'h11);
        applyStimulus(1'b1, 32'h22);
        applyStimulus(1'b1, 32'h33);
        n = 0;
        while (cyc + 1 < busyUntil && n < 400) begin
            applyStimulus(1'b0, 32'd0);
            n++;
        end
        applyStimulus(1'b1, 32'h44);
        checkValue("same-edge count", {29'd0, dut.u_fifo.count}, 32'd2);
        waitIdle("same-edge", 2000);
        e = '{8'h11, 8'h22, 8'h33, 8'h44};
        checkRx("same-edge", e);

        // Reset during data bit 3 of 0xF0 with two bytes queued
        applyStimulus(1'b1, 32'hF0);
        applyStimulus(1'b1, 32'hAA);
        applyStimulus(1'b1, 32'hBB);
        n = 0;
        while (cyc != frameStart + 4 * BIT_CLKS + 5 && n < 200) begin
            applyStimulus(1'b0, 32'd0);
            n++;
        end
        checkValue("midframe target reached", {31'd0, n < 200}, 32'd1);
        #3 reset = 1'b0;
        #1;
        checkValue("async reset tx",       {31'd0, tx},       32'd1);
        checkValue("async reset busy",     {31'd0, busy},     32'd0);
        checkValue("async reset full",     {31'd0, full},     32'd0);
        checkValue("async reset overflow", {31'd0, overflow}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        checkValue("reset held tx", {31'd0, tx}, 32'd1);
        #3 reset = 1'b1;
        rxQ.delete();
        idle(300);
        checkValue("no frames after reset", rxQ.size(), 0);

        // Randomised traffic against the model
        rxQ.delete();
        sentQ.delete();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0, $urandom());
        end
        waitIdle("random", 2000);
        e = sentQ;
        checkRx("random", e);

        checkValue("framing errors", framingErrors, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
